// File: rtl/proc2_feeder.sv
// ============================================================================
// proc2_feeder
// ----------------------------------------------------------------------------
// Program sequencer for the proc2 datapath. It fetches 9-bit instruction
// words from a synchronous program memory and drives the processor's Run/Done
// handshake, one instruction at a time. For an mvi instruction (opcode 001)
// the following memory word is fetched as the immediate. That word is
// presented on DIN one edge after the instruction word, which lines it up
// with the processor's T1 step. Opcode 111 halts the sequencer.
//
// Parameters
//   ADDR_W  program memory address width; the PC wraps modulo 2**ADDR_W
//   TMO     watchdog limit in EXEC cycles (watchdog build only)
//
// Ports
//   Clock    in   1       single clock, rising edge
//   Resetn   in   1       asynchronous, active-low reset
//   Start    in   1       level; starts execution from IDLE or HALTED
//   MemAddr  out  ADDR_W  program memory address (always the PC), registered
//   MemData  in   9       program memory read data, valid one cycle after
//                         MemAddr changes
//   DIN      out  9       word presented to the processor, registered
//   Run      out  1       request to the processor, registered
//   Done     in   1       processor instruction-complete pulse
//   Busy     out  1       high in every state except IDLE and HALTED
//   Halted   out  1       high in HALTED
//   Err      out  1       sticky watchdog error; constant 0 without watchdog
//
// Build option
//   FEEDER_TIMEOUT_EN  when defined, a watchdog counts EXEC cycles. If TMO
//                      cycles pass without Done, it raises Err, drops Run and
//                      halts. Err clears on Start or reset.
// ============================================================================
module proc2_feeder #(
   parameter int ADDR_W = 5,
   parameter int TMO    = 15
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [8:0]        MemData,
   output logic [8:0]        DIN,
   output logic              Run,
   input  logic              Done,
   output logic              Busy,
   output logic              Halted,
   output logic              Err
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD_I, S_LD_I, S_RD_M, S_LD_M,
      S_ISSUE, S_EXEC, S_GAP, S_HALTED
   } state_t;

   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [8:0]        instr_q, imm_q, din_q, din_d;
   logic              run_q, run_d;
   logic              pc_clear, pc_inc, load_instr, load_imm;
   logic              is_mvi;
   logic              timeout;

   assign is_mvi = (instr_q[8:6] == OP_MVI);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // The DIN and Run values are worked out from the state being entered, so
   // the registered outputs are already valid during that state. On the way
   // into ISSUE straight from LD_I, INSTR has not been written yet, so the
   // word is taken directly from MemData.
   always_comb begin
      state_d    = state_q;
      pc_clear   = 1'b0;
      pc_inc     = 1'b0;
      load_instr = 1'b0;
      load_imm   = 1'b0;
      din_d      = din_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               state_d  = S_RD_I;
               pc_clear = 1'b1;
            end
         end
         S_RD_I: state_d = S_LD_I;
         S_LD_I: begin
            load_instr = 1'b1;
            pc_inc     = 1'b1;
            if (MemData[8:6] == OP_HALT)     state_d = S_HALTED;
            else if (MemData[8:6] == OP_MVI) state_d = S_RD_M;
            else                             state_d = S_ISSUE;
         end
         S_RD_M: state_d = S_LD_M;
         S_LD_M: begin
            load_imm = 1'b1;
            pc_inc   = 1'b1;
            state_d  = S_ISSUE;
         end
         S_ISSUE: state_d = S_EXEC;
         S_EXEC: begin
            if (Done)         state_d = S_GAP;
            else if (timeout) state_d = S_HALTED;
         end
         S_GAP:   state_d = S_RD_I;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_ISSUE)
         din_d = load_instr ? MemData : instr_q;
      else if (state_d == S_EXEC && state_q == S_ISSUE)
         din_d = is_mvi ? imm_q : instr_q;

      run_d = (state_d == S_ISSUE) || (state_d == S_EXEC);
   end

   // Datapath registers: PC, latched instruction and immediate, and the
   // registered processor-facing outputs.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pc_q    <= '0;
         instr_q <= '0;
         imm_q   <= '0;
         din_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         if (pc_clear)    pc_q <= '0;
         else if (pc_inc) pc_q <= pc_q + ADDR_W'(1);
         if (load_instr)  instr_q <= MemData;
         if (load_imm)    imm_q   <= MemData;
         din_q <= din_d;
         run_q <= run_d;
      end
   end

`ifdef FEEDER_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TMO + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

   logic [CNT_W-1:0] wd_cnt_q;
   logic             err_q;

   // The count value is the number of EXEC cycles already completed. The
   // watchdog fires on the edge that closes cycle number TMO. A Done sampled
   // on that same edge still wins.
   assign timeout = (state_q == S_EXEC) && (wd_cnt_q == CNT_LAST);

   // The counter restarts on every entry to ISSUE. Err can only be set on the
   // way out of EXEC, and Start is only honoured in IDLE or HALTED, so the
   // clear and the set never compete.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_d == S_ISSUE)                         wd_cnt_q <= '0;
         else if (state_q == S_EXEC && !timeout)         wd_cnt_q <= wd_cnt_q + CNT_W'(1);
         if (Start && (state_q == S_IDLE || state_q == S_HALTED)) err_q <= 1'b0;
         else if (state_q == S_EXEC && !Done && timeout) err_q <= 1'b1;
      end
   end

   assign Err = err_q;
`else
   // TMO has no role without the watchdog; this only keeps it referenced.
   logic unused_tmo;
   assign unused_tmo = ^TMO;
   assign timeout    = 1'b0;
   assign Err        = 1'b0;
`endif

   assign MemAddr = pc_q;
   assign DIN     = din_q;
   assign Run     = run_q;
   assign Busy    = (state_q != S_IDLE) && (state_q != S_HALTED);
   assign Halted  = (state_q == S_HALTED);

endmodule
